pipe_reg_chain: RTL
===================

# pipe_reg_chain

Parametrised elastic pipeline register: a chain of DEPTH data registers of WIDTH bits, each with a valid bit, linked by a valid/ready handshake. It generalises the datapath register used between MIPS datapath stages. It adds stall back-pressure, bubble collapsing, synchronous flush, a programmable reset value and an occupancy count. It sits between datapath stages, for example as the basis of the IF/ID and ID/EX pipeline registers.

## Interface
- WIDTH, 32, data bits per stage (>=1)
- DEPTH, 1, number of register stages (>=1)
- RST_VAL, 0, value loaded into every data register on reset (WIDTH bits)
- CW, $clog2(DEPTH+1), count width (derived, not overridden)

- clk  in  1  clock, all state on rising edge
- rst  in  1  reset, asynchronous, active-low
- flush  in  1  synchronous flush, active-high
- in_valid  in  1  producer has data
- in_ready  out  1  chain accepts data this cycle
- in_data  in  WIDTH  producer data
- out_valid  out  1  valid bit of stage DEPTH-1
- out_ready  in  1  consumer accepts data this cycle
- out_data  out  WIDTH  data register of stage DEPTH-1
- count  out  CW  number of valid stages

## Operation
- State: v[i], d[i] for i = 0..DEPTH-1. Stage 0 is the input end; stage DEPTH-1 drives out_valid/out_data.
- Advance enables (combinational):
  - adv[DEPTH-1] = !v[DEPTH-1] | out_ready
  - adv[i] = !v[i] | adv[i+1]
- in_ready = adv[0] & !flush.
- Transfers:
  - Input transfer: in_valid & in_ready.
  - Output transfer: out_valid & out_ready. Counted even in a flush cycle.
- Stage update on clk when adv[i]:
  - Stage 0: v[0] <= in_valid & !flush.
  - Stage i>0: v[i] <= v[i-1] & !flush.
  - d[i] loads its source (in_data or d[i-1]) only when the source is valid. Otherwise d[i] holds.
  - Stages with adv[i]=0 hold v and d.
- Bubble collapsing: an empty stage always accepts from its predecessor, even when downstream is stalled. No data is lost or duplicated.
- flush=1: every v[i] clears at the next edge, regardless of adv. d registers are not cleared. in_ready=0 that cycle, so in_data is dropped.
- count = popcount(v), registered. Next value is the popcount of the next v.
- Data of a stage whose v=0 is don't-care to consumers. It holds the last loaded value, or RST_VAL after reset.

## Timing
- Reset (rst=0, asynchronous): all v=0, all d=RST_VAL, out_valid=0, out_data=RST_VAL, count=0.
- During reset, in_ready=1 unless flush=1 (combinational from v=0).
- Release of rst is synchronous to the next rising edge. The first transfer is possible on the first edge with rst=1.
- Latency: in an empty chain with out_ready=1, data accepted at edge t appears on out_data/out_valid after edge t+DEPTH-1, i.e. DEPTH cycles after presentation.
- Throughput: 1 item/cycle sustained with out_ready=1.
- Full: all v=1 and out_ready=0 gives in_ready=0.
- Full with out_ready=1 gives in_ready=1. Simultaneous in/out transfer keeps count at DEPTH.
- Combinational path out_ready -> in_ready through DEPTH stages is permitted. No registered-ready variant exists in this block.
- Reset asserted mid-transfer: state clears immediately and in-flight data is lost. Outputs take reset values asynchronously.
- Flush and reset together: reset dominates.

## Test plan
- Reset: WIDTH=32, DEPTH=3, RST_VAL=32'hDEAD_BEEF. Assert rst mid-stream -> out_valid=0, out_data=32'hDEADBEEF, count=0 without a clock edge.
- Streaming: DEPTH=3, out_ready=1, send 1,2,3,4 on consecutive cycles. Required response:
  - out_data 1,2,3,4 on consecutive cycles.
  - The first output appears 3 cycles after 1 is presented.
  - in_ready stays 1 throughout.
- Back-pressure: DEPTH=3, out_ready=0, send 8'hA1..8'hA4. Required response:
  - 3 accepted, count=3, in_ready=0, A4 held by the producer.
  - Raise out_ready: out_data is A1, A2, A3, A4 in order, with no duplicates.
- Bubble collapse: DEPTH=4, send A, idle 2 cycles, send B, with out_ready=0. Required response:
  - A reaches stage 3 and B advances to stage 2.
  - count=2.
  - After out_ready=1, A then B on consecutive cycles.
- Flush: DEPTH=2, chain full, out_ready=1, flush=1 with in_valid=1, data 5. Required response:
  - The current out_data is consumed that cycle.
  - Next cycle out_valid=0, count=0, and 5 is not accepted.
- DEPTH=1 boundary: full with out_ready=1 and in_valid=1 -> simultaneous in/out transfer every cycle, count stays 1.

Source files
------------

// File: rtl/pipe_reg_chain.sv
`default_nettype none
// ============================================================================
// Module      : pipe_reg_chain
// Description : Elastic pipeline register chain. DEPTH stages of WIDTH-bit
//               data, each with a valid bit and a valid/ready handshake.
//               Supports stall back-pressure, bubble collapsing,
//               synchronous flush, a programmable reset value and an
//               occupancy count.
// Revision    : 1.0 - initial release
// ============================================================================
module pipe_reg_chain #(
    parameter int              WIDTH   = 32,
    parameter int              DEPTH   = 1,
    parameter logic [WIDTH-1:0] RST_VAL = '0,
    localparam int             CW      = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [CW-1:0]    count
);

    logic [DEPTH-1:0] v_q;
    logic [DEPTH-1:0] v_d;
    logic [DEPTH-1:0] adv;
    logic [DEPTH-1:0] src_valid;
    logic [WIDTH-1:0] src_data [DEPTH];
    logic [WIDTH-1:0] d_q      [DEPTH];
    logic [CW-1:0]    count_q;
    logic [CW-1:0]    count_d;

    // Each stage's source: the producer for stage 0, the previous stage otherwise.
    for (genvar i = 0; i < DEPTH; i++) begin : g_src
        if (i == 0) begin : g_head
            assign src_valid[i] = in_valid;
            assign src_data[i]  = in_data;
        end else begin : g_body
            assign src_valid[i] = v_q[i-1];
            assign src_data[i]  = d_q[i-1];
        end
    end

    // A stage may advance when it or any stage downstream of it is empty,
    // or the consumer is taking the last stage (ripples from the output end).
    always_comb begin
        logic acc;
        acc = out_ready;
        adv = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            acc    = acc | ~v_q[i];
            adv[i] = acc;
        end
    end

    // Next valid bits: shift where enabled, hold where stalled, clear on flush.
    always_comb begin
        v_d = v_q;
        for (int i = 0; i < DEPTH; i++) begin
            if (adv[i]) begin
                v_d[i] = src_valid[i];
            end
        end
        if (flush) begin
            v_d = '0;
        end
    end

    // Occupancy of the next state, so the registered count tracks v_q exactly.
    always_comb begin
        count_d = '0;
        for (int i = 0; i < DEPTH; i++) begin
            count_d = count_d + CW'(v_d[i]);
        end
    end

    // Valid bits and occupancy count.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            v_q     <= '0;
            count_q <= '0;
        end else begin
            v_q     <= v_d;
            count_q <= count_d;
        end
    end

    // Data registers load only valid data; otherwise they keep their last value.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                d_q[i] <= RST_VAL;
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (adv[i] && src_valid[i]) begin
                    d_q[i] <= src_data[i];
                end
            end
        end
    end

    assign in_ready  = adv[0] & ~flush;
    assign out_valid = v_q[DEPTH-1];
    assign out_data  = d_q[DEPTH-1];
    assign count     = count_q;

endmodule
`default_nettype wire
